apb_master_nslv: RTL

APB_MASTER_NSLV -- requirements
Module: apb_master_nslv

---
 rtl/apb_master_nslv.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/apb_master_nslv.sv
// APB master bridging a simple valid/ready request port onto NUM_SLAVES APB slaves.
// Slave index comes from the top address bits; a stuck slave is aborted after TIMEOUT wait states.
module apb_master_nslv #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int NUM_SLAVES = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                             pclk,
   input  logic                             presetn,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_write,
   input  logic [ADDR_WIDTH-1:0]            req_addr,
   input  logic [DATA_WIDTH-1:0]            req_wdata,
   output logic                             rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic                             rsp_err,
   output logic                             rsp_timeout,
   output logic [NUM_SLAVES-1:0]            pselx,
   output logic                             penable,
   output logic                             pwrite,
   output logic [ADDR_WIDTH-1:0]            paddr,
   output logic [DATA_WIDTH-1:0]            pwdata,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]            pready,
   input  logic [NUM_SLAVES-1:0]            pslverr,
   output logic [DATA_WIDTH-1:0]            read_data
);

   localparam int SEL_BITS = $clog2(NUM_SLAVES);
   localparam int CNT_BITS = $clog2(TIMEOUT);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;

   logic [1:0]            state_q,       state_d;
   logic [SEL_BITS-1:0]   idx_q,         idx_d;
   logic [NUM_SLAVES-1:0] pselx_q,       pselx_d;
   logic                  penable_q,     penable_d;
   logic                  pwrite_q,      pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
   logic                  rsp_valid_q,   rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
   logic                  rsp_err_q,     rsp_err_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic [DATA_WIDTH-1:0] read_data_q,   read_data_d;
   logic [CNT_BITS-1:0]   wait_cnt_q,    wait_cnt_d;

   logic [SEL_BITS-1:0]   req_idx;
   logic                  decode_ok;
   logic                  sel_ready;
   logic                  sel_err;
   logic [DATA_WIDTH-1:0] sel_rdata;

   assign req_ready = (state_q == IDLE) && presetn;
   assign req_idx   = req_addr[ADDR_WIDTH-1 -: SEL_BITS];
   assign decode_ok = 32'(req_idx) < NUM_SLAVES;

   // Only the addressed slave's handshake is visible to the FSM.
   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == SEL_BITS'(i)) begin
            sel_ready = pready[i];
            sel_err   = pslverr[i];
            sel_rdata = prdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      pselx_d       = pselx_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      read_data_d   = read_data_q;
      wait_cnt_d    = wait_cnt_q;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               idx_d    = req_idx;
               pwrite_d = req_write;
               paddr_d  = req_addr;
               pwdata_d = req_wdata;
               if (decode_ok) begin
                  state_d    = SETUP;
                  pselx_d    = NUM_SLAVES'(1) << req_idx;
                  wait_cnt_d = '0;
               end else begin
                  rsp_valid_d   = 1'b1;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b0;
                  rsp_rdata_d   = '0;
               end
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            // A ready slave wins over a timeout landing on the same cycle.
            if (sel_ready) begin
               state_d       = IDLE;
               pselx_d       = '0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = sel_err;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = pwrite_q ? '0 : sel_rdata;
               if (!pwrite_q && !sel_err) read_data_d = sel_rdata;
            end else if (wait_cnt_q == CNT_BITS'(TIMEOUT-1)) begin
               state_d       = IDLE;
               pselx_d       = '0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
      if (!presetn) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         pselx_q       <= '0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         read_data_q   <= '0;
         wait_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         pselx_q       <= pselx_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         read_data_q   <= read_data_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   assign pselx       = pselx_q;
   assign penable     = penable_q;
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign read_data   = read_data_q;

endmodule
